// File: rtl/calc1_pkg.sv
// calc1_pkg -- definitions shared by the calc1 port responder and its ALU.
//   DATA_W      : operand/result width (32)
//   cmd_t       : 4-bit command code, bit 0 = MSB
//   resp_t      : 2-bit response code, bit 0 = MSB
//   state_t     : responder FSM states (IDLE, OPND2, EXEC, RESP)
// Compile-time option: CALC1_SHIFT_EN (enables the cmd 5/6 shifter).
package calc1_pkg;

    localparam int DATA_W = 32;

    typedef logic [0:3]        cmd_t;
    typedef logic [0:1]        resp_t;
    typedef logic [0:DATA_W-1] data_t;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_SHL = 4'd5;
    localparam cmd_t CMD_SHR = 4'd6;

    localparam resp_t RESP_NONE = 2'd0;
    localparam resp_t RESP_OK   = 2'd1;
    localparam resp_t RESP_ERR  = 2'd2;
    localparam resp_t RESP_RSVD = 2'd3;  // never produced

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPND2 = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// calc1_alu -- purely combinational ALU for the calc1 port responder.
//   cmd    in  : command code (ADD, SUB, and SHL/SHR when CALC1_SHIFT_EN)
//   op1    in  : operand 1
//   op2    in  : operand 2 (shifts use its 5 LSBs, op2[27:31])
//   result out : result value, 0 whenever resp is ERR
//   resp   out : OK or ERR (RSVD is never produced)
// Compile-time option: CALC1_SHIFT_EN -- without it cmd 5/6 are invalid and
// no shifter is built.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [0:3]        cmd,
    input  logic [0:DATA_W-1] op1,
    input  logic [0:DATA_W-1] op2,
    output logic [0:DATA_W-1] result,
    output logic [0:1]        resp
);

    // One extra bit on the left captures the carry out of the add.
    logic [0:DATA_W] sum_ext;

    assign sum_ext = {1'b0, op1} + {1'b0, op2};

`ifdef CALC1_SHIFT_EN
    logic [0:4] sh_amt;
    assign sh_amt = op2[27:31];
`endif

    always_comb begin
        result = '0;
        resp   = RESP_ERR;
        case (cmd)
            CMD_ADD: begin
                if (!sum_ext[0]) begin
                    result = sum_ext[1:DATA_W];
                    resp   = RESP_OK;
                end
            end
            CMD_SUB: begin
                // Negative results are reported as underflow, not wrapped.
                if (op2 <= op1) begin
                    result = op1 - op2;
                    resp   = RESP_OK;
                end
            end
`ifdef CALC1_SHIFT_EN
            CMD_SHL: begin
                result = op1 << sh_amt;
                resp   = RESP_OK;
            end
            CMD_SHR: begin
                result = op1 >> sh_amt;
                resp   = RESP_OK;
            end
`endif
            default: begin
                result = '0;
                resp   = RESP_ERR;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1_port_responder -- two-beat request port in front of calc1_alu.
//   c_clk       in  : clock, rising edge
//   reset_n     in  : asynchronous active-low reset
//   req_cmd_in  in  : command, sampled in IDLE only; 0 = no-op
//   req_data_in in  : operand 1 with the command, operand 2 the cycle after
//   out_resp    out : response code, nonzero for exactly one cycle (RESP)
//   out_data    out : result, valid only while out_resp is nonzero, else 0
//   busy        out : high in OPND2, EXEC and RESP
// Compile-time option: CALC1_SHIFT_EN (passed through to calc1_alu).
// Flow: IDLE -(cmd)-> OPND2 -> EXEC -> RESP -> IDLE. Commands arriving
// outside IDLE are dropped.
module calc1_port_responder
    import calc1_pkg::*;
(
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [0:3]        req_cmd_in,
    input  logic [0:DATA_W-1] req_data_in,
    output logic [0:1]        out_resp,
    output logic [0:DATA_W-1] out_data,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic [0:3]        cmd_reg, cmd_next;
    logic [0:DATA_W-1] op1_reg, op1_next;
    logic [0:DATA_W-1] op2_reg, op2_next;
    logic [0:DATA_W-1] result_reg, result_next;
    logic [0:1]        resp_code_reg, resp_code_next;
    // Cleared by reset and set on the first edge afterwards, so the edge
    // that follows reset release never accepts a command.
    logic              ready_reg;

    logic [0:DATA_W-1] alu_result;
    logic [0:1]        alu_resp;

    calc1_alu u_alu (
        .cmd    (cmd_reg),
        .op1    (op1_reg),
        .op2    (op2_reg),
        .result (alu_result),
        .resp   (alu_resp)
    );

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cmd_reg       <= CMD_NOP;
            op1_reg       <= '0;
            op2_reg       <= '0;
            result_reg    <= '0;
            resp_code_reg <= RESP_NONE;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_reg       <= cmd_next;
            op1_reg       <= op1_next;
            op2_reg       <= op2_next;
            result_reg    <= result_next;
            resp_code_reg <= resp_code_next;
            ready_reg     <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cmd_next       = cmd_reg;
        op1_next       = op1_reg;
        op2_next       = op2_reg;
        result_next    = result_reg;
        resp_code_next = resp_code_reg;
        case (state_reg)
            IDLE: begin
                if (ready_reg && (req_cmd_in != CMD_NOP)) begin
                    cmd_next   = req_cmd_in;
                    op1_next   = req_data_in;
                    state_next = OPND2;
                end
            end
            OPND2: begin
                op2_next   = req_data_in;
                state_next = EXEC;
            end
            EXEC: begin
                result_next    = alu_result;
                resp_code_next = alu_resp;
                state_next     = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset clears them
    // at once, without waiting for a clock edge.
    always_comb begin
        out_resp = RESP_NONE;
        out_data = '0;
        if (state_reg == RESP) begin
            out_resp = resp_code_reg;
            out_data = result_reg;
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_calc1_port_responder.sv
module tb_calc1_port_responder;

    logic        c_clk;
    logic        reset_n;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        busy;

    int checks;
    int failures;

    calc1_port_responder dut (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction: command beat, operand-2 beat, then checks on
    // each following cycle (sampled 1ns after the rising edge).
    task automatic run_op(input string name, input logic [3:0] cmd,
                          input logic [31:0] op1, input logic [31:0] op2,
                          input logic [1:0] exp_resp, input logic [31:0] exp_data);
        @(posedge c_clk); #1;
        req_cmd_in  = cmd;
        req_data_in = op1;
        @(posedge c_clk); #1;          // command sampled, now OPND2
        check({name, "_busy_opnd2"}, {31'd0, busy}, 32'd1);
        req_cmd_in  = 4'd0;
        req_data_in = op2;
        @(posedge c_clk); #1;          // EXEC
        check({name, "_resp_exec"}, {30'd0, out_resp}, 32'd0);
        req_data_in = 32'd0;
        @(posedge c_clk); #1;          // RESP
        check({name, "_resp"}, {30'd0, out_resp}, {30'd0, exp_resp});
        check({name, "_data"}, out_data, exp_data);
        @(posedge c_clk); #1;          // back to IDLE
        check({name, "_resp_after"}, {30'd0, out_resp}, 32'd0);
        check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        $display("txn %s cmd=%0d op1=%h op2=%h -> resp=%0d data=%h", name, cmd, op1, op2, exp_resp, exp_data);
    endtask

    initial begin
        int busy_cnt;
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;

        vecs[0]  = '{4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000};
        vecs[1]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[2]  = '{4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000};
        vecs[3]  = '{4'd2, 32'h0000_000F, 32'h0000_000F, 2'd1, 32'h0000_0000};
        vecs[4]  = '{4'd3, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[5]  = '{4'd4, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[6]  = '{4'd7, 32'h0000_0010, 32'h0000_0002, 2'd2, 32'h0000_0000};
        vecs[7]  = '{4'd15, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[8]  = '{4'd1, 32'h0000_0002, 32'h0000_0003, 2'd1, 32'h0000_0005};
        vecs[9]  = '{4'd2, 32'h0000_000A, 32'h0000_0003, 2'd1, 32'h0000_0007};
        vecs[10] = '{4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd1, 32'hFFFF_FFFF};
        vecs[11] = '{4'd2, 32'h8000_0000, 32'h0000_0001, 2'd1, 32'h7FFF_FFFF};
`ifdef CALC1_SHIFT_EN
        vecs[12] = '{4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000};
        vecs[13] = '{4'd6, 32'h8000_0000, 32'h0000_0023, 2'd1, 32'h1000_0000};
`else
        vecs[12] = '{4'd5, 32'h0000_0001, 32'h0000_001F, 2'd2, 32'h0000_0000};
        vecs[13] = '{4'd6, 32'h8000_0000, 32'h0000_0023, 2'd2, 32'h0000_0000};
`endif

        // Reset state
        repeat (3) @(posedge c_clk);
        #1;
        check("rst_resp", {30'd0, out_resp}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Release between edges with a command already present: the first
        // edge must ignore it, the second must accept it.
        req_cmd_in  = 4'd1;
        req_data_in = 32'h0000_0001;
        @(negedge c_clk);
        reset_n = 1'b1;
        @(posedge c_clk); #1;
        check("rel_edge_busy", {31'd0, busy}, 32'd0);
        @(posedge c_clk); #1;
        check("second_edge_busy", {31'd0, busy}, 32'd1);
        req_cmd_in  = 4'd0;
        req_data_in = 32'h0000_0001;
        @(posedge c_clk); #1;
        req_data_in = 32'd0;
        @(posedge c_clk); #1;
        check("first_cmd_resp", {30'd0, out_resp}, 32'd1);
        check("first_cmd_data", out_data, 32'd2);
        $display("txn first_cmd 1+1 -> resp=%0d data=%h", out_resp, out_data);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].op1, vecs[i].op2,
                   vecs[i].resp, vecs[i].data);
        end

        // cmd 0 never responds
        req_cmd_in  = 4'd0;
        req_data_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge c_clk); #1;
            check($sformatf("nop_resp%0d", i), {30'd0, out_resp}, 32'd0);
            check($sformatf("nop_busy%0d", i), {31'd0, busy}, 32'd0);
        end
        $display("txn nop -> no response");

        // 2+3, then 7+7 issued during EXEC is dropped
        busy_cnt = 0;
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd1;
        req_data_in = 32'd2;
        @(posedge c_clk); #1;          // OPND2
        busy_cnt += busy;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd3;
        @(posedge c_clk); #1;          // EXEC
        busy_cnt += busy;
        req_cmd_in  = 4'd1;
        req_data_in = 32'd7;
        @(posedge c_clk); #1;          // RESP
        busy_cnt += busy;
        check("drop_resp", {30'd0, out_resp}, 32'd1);
        check("drop_data", out_data, 32'd5);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge c_clk); #1;
            busy_cnt += busy;
            check($sformatf("drop_quiet%0d", i), {30'd0, out_resp}, 32'd0);
        end
        check("drop_busy_cycles", busy_cnt, 32'd3);
        $display("txn 2+3 with dropped 7+7 -> busy_cycles=%0d", busy_cnt);

        // Reset during EXEC of 4+4 aborts it
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd1;
        req_data_in = 32'd4;
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd4;
        @(posedge c_clk); #1;          // EXEC
        reset_n = 1'b0;
        #1;
        check("abort_resp", {30'd0, out_resp}, 32'd0);
        check("abort_data", out_data, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        req_data_in = 32'd0;
        @(negedge c_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge c_clk); #1;
            check($sformatf("abort_quiet%0d", i), {30'd0, out_resp}, 32'd0);
        end
        $display("txn 4+4 aborted by reset -> no response");
        run_op("after_abort", 4'd1, 32'd4, 32'd4, 2'd1, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
